mux_chan_scanner: RTL and testbench

- Sequencer that sits directly upstream of the 4:1 two-bit channel mux.
- Drives the mux select, waits a programmable settle time, then captures the mux output.
- Presents each captured sample with its channel index on a valid/ready interface.
- Steps through the enabled channels round-robin and flags each completed frame.

---
 rtl/mux_scan_pkg.sv | 27 ++
 rtl/mux_scan_next_chan.sv | 36 +++
 rtl/mux_chan_scanner.sv | 150 +++++++++++++++
 tb/tb_mux_chan_scanner.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//   Shared definitions for the 4:1 channel-mux scanner.
//   NUM_CH / SEL_W : channel count and select width (fixed at 4 / 2).
//   scan_state_e   : scanner FSM state encoding (2 bits).
//   first_chan()   : lowest-index set bit of a channel mask (0 if none).
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } scan_state_e;

  function automatic logic [SEL_W-1:0] first_chan(input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] res;
    res = '0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) res = i[SEL_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_next_chan.sv
// mux_scan_next_chan
//   Combinational rotate-priority search: finds the first enabled channel
//   strictly after cur, wrapping 3->0. If cur is the only enabled channel the
//   search comes all the way round and returns cur itself.
//   cur  : current channel index
//   mask : channel enable mask (bit i = channel i)
//   nxt  : next channel to scan (equals cur when mask is empty)
//   wrap : 1 when nxt <= cur, i.e. the next channel starts a new pass
module mux_scan_next_chan
  import mux_scan_pkg::*;
(
  input  logic [SEL_W-1:0]  cur,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrap
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    nxt   = cur;
    idx   = cur;
    found = 1'b0;
    // Offset k = NUM_CH wraps idx back to cur, covering the single-channel case.
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = cur + k[SEL_W-1:0];
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/mux_chan_scanner.sv
// mux_chan_scanner
//   Drives the select of a 4:1 mux, waits dwell settle cycles, captures the
//   mux output and offers it with its channel index on a valid/ready port.
//   Enabled channels are visited round-robin; frame_done flags each pass.
//
//   Handshake: smp_valid rises with a captured sample and smp_data/smp_chan
//   stay frozen until the first rising edge where smp_valid && smp_ready; the
//   sample is consumed on that edge and smp_valid never falls otherwise
//   (except on reset).
//
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     en                scan enable
//     chan_mask [3:0]   channels to scan
//     dwell             settle cycles after a select change
//     sel [1:0]         mux select
//     mux_o             mux output being sampled
//     smp_data/smp_chan captured sample and its channel
//     smp_valid/ready   sample handshake
//     frame_done        1-cycle pulse after the last channel of a pass
//     busy              FSM not idle
//     dbg_state         current FSM state
//   Optional (macro MUX_SCAN_FRAME_CNT_EN):
//     frame_cnt [7:0]   count of frame_done pulses, wraps 255->0
//     smp_first         sample is from the lowest enabled channel
module mux_chan_scanner
  import mux_scan_pkg::*;
#(
  parameter int DATA_W  = 2,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_CH-1:0]  chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  input  logic [DATA_W-1:0]  mux_o,
  output logic [DATA_W-1:0]  smp_data,
  output logic [SEL_W-1:0]   smp_chan,
  output logic               smp_valid,
  input  logic               smp_ready,
  output logic               frame_done,
  output logic               busy,
`ifdef MUX_SCAN_FRAME_CNT_EN
  output logic [7:0]         frame_cnt,
  output logic               smp_first,
`endif
  output scan_state_e        dbg_state
);

  scan_state_e        state_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [SEL_W-1:0]   sel_q;
  logic [DATA_W-1:0]  smp_data_q;
  logic [SEL_W-1:0]   smp_chan_q;
  logic               smp_valid_q;
  logic               frame_done_q;
  logic [SEL_W-1:0]   nxt_chan_d;
  logic               wrap_d;
`ifdef MUX_SCAN_FRAME_CNT_EN
  logic [7:0]         frame_cnt_q;
  logic               smp_first_q;
`endif

  mux_scan_next_chan u_next_chan (
    .cur  (sel_q),
    .mask (chan_mask),
    .nxt  (nxt_chan_d),
    .wrap (wrap_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      smp_data_q   <= '0;
      smp_chan_q   <= '0;
      smp_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef MUX_SCAN_FRAME_CNT_EN
      frame_cnt_q  <= '0;
      smp_first_q  <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
`ifdef MUX_SCAN_FRAME_CNT_EN
      if (frame_done_q) frame_cnt_q <= frame_cnt_q + 8'd1;
`endif
      case (state_q)
        ST_IDLE: begin
          if (en && (|chan_mask)) begin
            sel_q   <= first_chan(chan_mask);
            cnt_q   <= dwell;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!en) begin
            // Abort: no sample, select left where it was.
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            smp_data_q  <= mux_o;
            smp_chan_q  <= sel_q;
            smp_valid_q <= 1'b1;
`ifdef MUX_SCAN_FRAME_CNT_EN
            smp_first_q <= (sel_q == first_chan(chan_mask));
`endif
            state_q     <= ST_PRESENT;
          end else begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end
        end
        ST_PRESENT: begin
          // en is ignored until the pending sample has been taken.
          if (smp_ready) begin
            smp_valid_q <= 1'b0;
`ifdef MUX_SCAN_FRAME_CNT_EN
            smp_first_q <= 1'b0;
`endif
            if (en && (|chan_mask)) begin
              sel_q        <= nxt_chan_d;
              cnt_q        <= dwell;
              state_q      <= ST_SETTLE;
              frame_done_q <= wrap_d;
            end else begin
              state_q      <= ST_IDLE;
              frame_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel        = sel_q;
  assign smp_data   = smp_data_q;
  assign smp_chan   = smp_chan_q;
  assign smp_valid  = smp_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;
`ifdef MUX_SCAN_FRAME_CNT_EN
  assign frame_cnt  = frame_cnt_q;
  assign smp_first  = smp_first_q;
`endif

endmodule

// File: tb/tb_mux_chan_scanner.sv
// tb_mux_chan_scanner
//   Directed bench for mux_chan_scanner. The mux is modelled as
//   mux_o = sel ^ key so captured data depends on the select in force at
//   capture time. Free-running scans come from a vector table; ready
//   back-pressure, abort, mid-scan mask change, scan end and reset are
//   hand-written sequences. Build with +define+MUX_SCAN_FRAME_CNT_EN to also
//   cover frame_cnt / smp_first.
module tb_mux_chan_scanner;
  import mux_scan_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  mask;
  logic [7:0]  dwell;
  logic [1:0]  sel;
  logic [1:0]  key;
  logic [1:0]  mux_o;
  logic [1:0]  smp_data;
  logic [1:0]  smp_chan;
  logic        smp_valid;
  logic        ready;
  logic        frame_done;
  logic        busy;
  scan_state_e dbg_state;
`ifdef MUX_SCAN_FRAME_CNT_EN
  logic [7:0]  frame_cnt;
  logic        smp_first;
`endif

  always #5 clk = ~clk;
  assign mux_o = sel ^ key;

  mux_chan_scanner #(.DATA_W(2), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .chan_mask  (mask),
    .dwell      (dwell),
    .sel        (sel),
    .mux_o      (mux_o),
    .smp_data   (smp_data),
    .smp_chan   (smp_chan),
    .smp_valid  (smp_valid),
    .smp_ready  (ready),
    .frame_done (frame_done),
    .busy       (busy),
`ifdef MUX_SCAN_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
    .smp_first  (smp_first),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  bit         fd_stray = 1'b0;
  logic [4:0] exp_q[$];   // {chan, data, frame_done}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; ready = 1'b0;
    mask = 4'd0; dwell = 8'd0; key = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge where smp_valid is first seen; cyc = negedges waited.
  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (smp_valid) begin
        ok = 1'b1;
        break;
      end
      if (frame_done) fd_stray = 1'b1;
    end
  endtask

  // With ready=1: wait for a sample, read it, then read frame_done one cycle later.
  task automatic take_sample(output logic [1:0] ch, output logic [1:0] dat,
                             output logic fd, output logic [1:0] s, output int lat,
                             output bit ok);
    wait_valid(lat, ok);
    ch  = smp_chan;
    dat = smp_data;
    s   = sel;
    @(negedge clk);
    fd = frame_done;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && !smp_valid) begin
        idle = 1'b1;
        break;
      end
    end
    check("drain_to_idle", idle, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] mask;
    logic [7:0] dwell;
    logic [1:0] key;
    logic [7:0] chans;  // sample s channel in chans[2s+:2]
    logic [3:0] fds;    // sample s frame_done in fds[s]
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [1:0] ch, dat, s, ch0, dat0, s0, ec;
    logic       fd;
    logic [4:0] exp_rec;
    int         lat;
    bit         ok;
    bit         seen;

    vecs[0] = '{mask: 4'b1111, dwell: 8'd3, key: 2'd0, chans: 8'b11_10_01_00, fds: 4'b1000};
    vecs[1] = '{mask: 4'b1010, dwell: 8'd0, key: 2'd3, chans: 8'b11_01_11_01, fds: 4'b1010};
    vecs[2] = '{mask: 4'b0100, dwell: 8'd1, key: 2'd1, chans: 8'b10_10_10_10, fds: 4'b1111};
    vecs[3] = '{mask: 4'b1001, dwell: 8'd2, key: 2'd2, chans: 8'b11_00_11_00, fds: 4'b1010};
    vecs[4] = '{mask: 4'b0110, dwell: 8'd5, key: 2'd0, chans: 8'b10_01_10_01, fds: 4'b1010};

    // ---- reset values ----
    rst_n = 1'b0; en = 1'b0; ready = 1'b0; mask = 4'd0; dwell = 8'd0; key = 2'd0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {sel, smp_data, smp_chan, smp_valid, frame_done, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- en with empty mask stays idle ----
    en = 1'b1; mask = 4'd0;
    repeat (3) @(negedge clk);
    check("empty_mask_busy", busy, 0);
    check("empty_mask_sel", sel, 0);

    // ---- table-driven free-running scans ----
    for (int r = 0; r < 5; r++) begin
      do_reset();
      mask = vecs[r].mask; dwell = vecs[r].dwell; key = vecs[r].key;
      ready = 1'b1; en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        ec = vecs[r].chans[2*k +: 2];
        exp_q.push_back({ec, ec ^ vecs[r].key, vecs[r].fds[k]});
      end
      for (int k = 0; k < 4; k++) begin
        take_sample(ch, dat, fd, s, lat, ok);
        check($sformatf("row%0d_s%0d_timeout", r, k), ok, 1);
        if (!ok) break;
        exp_rec = exp_q.pop_front();
        check($sformatf("row%0d_s%0d_chan_data_fd", r, k), {ch, dat, fd}, exp_rec);
        check($sformatf("row%0d_s%0d_sel", r, k), s, exp_rec[4:3]);
        if (k > 0) check($sformatf("row%0d_s%0d_latency", r, k), lat, vecs[r].dwell + 1);
      end
      exp_q.delete();
      en = 1'b0;
      wait_idle();
    end

    // ---- back-pressure: ready low for 10 cycles ----
    do_reset();
    mask = 4'b1111; dwell = 8'd2; key = 2'd1; ready = 1'b0; en = 1'b1;
    wait_valid(lat, ok);
    check("hold_timeout", ok, 1);
    ch0 = smp_chan; dat0 = smp_data; s0 = sel;
    check("hold_first_sample", {ch0, dat0}, {2'd0, 2'd1});
`ifdef MUX_SCAN_FRAME_CNT_EN
    check("hold_first_flag", smp_first, 1);
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_stable_%0d", i), {smp_valid, smp_chan, smp_data, sel}, {1'b1, ch0, dat0, s0});
    end
    ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", smp_valid, 0);
    take_sample(ch, dat, fd, s, lat, ok);
    check("hold_resume_sample", {ok, ch, dat, fd}, {1'b1, 2'd1, 2'd0, 1'b0});
`ifdef MUX_SCAN_FRAME_CNT_EN
    check("hold_second_not_first", smp_first, 0);
`endif
    en = 1'b0;
    wait_idle();

    // ---- abort mid-settle ----
    do_reset();
    mask = 4'b0100; dwell = 8'd20; ready = 1'b1; en = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_busy_before", busy, 1);
    check("abort_sel_before", sel, 2);
    en = 1'b0;
    @(negedge clk);
    check("abort_idle", {busy, dbg_state}, {1'b0, ST_IDLE});
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (smp_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    check("abort_sel_holds", sel, 2);

    // ---- mask change during settle of chan 1 ----
    do_reset();
    mask = 4'b1111; dwell = 8'd4; ready = 1'b1; en = 1'b1;
    take_sample(ch, dat, fd, s, lat, ok);
    check("mchg_s0", {ok, ch, fd}, {1'b1, 2'd0, 1'b0});
    mask = 4'b0100;
    take_sample(ch, dat, fd, s, lat, ok);
    check("mchg_s1", {ok, ch, dat, fd}, {1'b1, 2'd1, 2'd1, 1'b0});
    check("mchg_s1_latency", lat, 5);
    take_sample(ch, dat, fd, s, lat, ok);
    check("mchg_s2", {ok, ch, dat, fd}, {1'b1, 2'd2, 2'd2, 1'b1});
    take_sample(ch, dat, fd, s, lat, ok);
    check("mchg_s3", {ok, ch, dat, fd}, {1'b1, 2'd2, 2'd2, 1'b1});
    en = 1'b0;
    wait_idle();

    // ---- en dropped while presenting: sample kept, scan ends with frame_done ----
    do_reset();
    mask = 4'b0011; dwell = 8'd1; ready = 1'b0; en = 1'b1;
    wait_valid(lat, ok);
    check("end_timeout", ok, 1);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("end_sample_kept", {smp_valid, smp_chan, busy}, {1'b1, 2'd0, 1'b1});
    ready = 1'b1;
    @(negedge clk);
    check("end_frame_done", {frame_done, busy, smp_valid}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    check("end_frame_done_1cyc", frame_done, 0);

    // ---- asynchronous reset while a sample is pending ----
    do_reset();
    mask = 4'b1000; dwell = 8'd0; key = 2'd1; ready = 1'b0; en = 1'b1;
    wait_valid(lat, ok);
    check("rst_pending", {ok, smp_chan, smp_data}, {1'b1, 2'd3, 2'd2});
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", {sel, smp_data, smp_chan, smp_valid, frame_done, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(negedge clk);
    check("rst_no_frame_done", {frame_done, busy}, 0);

`ifdef MUX_SCAN_FRAME_CNT_EN
    // ---- frame counter wrap: single channel, dwell 0 -> one frame per sample ----
    do_reset();
    check("fcnt_reset", frame_cnt, 0);
    mask = 4'b0001; dwell = 8'd0; ready = 1'b1; en = 1'b1;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 2000 && pulses < 256; i++) begin
        @(negedge clk);
        if (frame_done) begin
          pulses++;
          if (pulses == 255) begin
            @(negedge clk);
            check("fcnt_255", frame_cnt, 255);
          end
        end
      end
      check("fcnt_pulses", pulses, 256);
      @(negedge clk);
      check("fcnt_wrap", frame_cnt, 0);
    end
    en = 1'b0;
    wait_idle();
`endif

    check("frame_done_stray", fd_stray, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
